// File: rtl/mul_4x4_i8_seq_pkg.sv
// Shared types and constants for the mul_4x4_i8 issue/collect sequencer.
//   SEQ_VSR_W     : width of the latency-tracking shift register (max LATENCY)
//   SEQ_CNT_W     : width of the in-flight / FIFO occupancy counters
//   IDENTITY_M    : 4x4 int8 identity, element (r,c) at [(4r+c)*8 +: 8]
//   seq_regs_t    : sequencer register set (matrices, issue regs, tracking)
//   SEQ_RESET     : register values applied on reset
//   mtx_write()   : replace one 8-bit element of a packed 4x4 matrix
package mul_4x4_i8_seq_pkg;

    localparam int SEQ_VSR_W = 16;   // supports LATENCY 1..16
    localparam int SEQ_CNT_W = 9;    // supports FIFO_DEPTH up to 256

    localparam logic [127:0] IDENTITY_M = 128'h01000000_00010000_00000100_00000001;

    typedef struct packed {
        logic [127:0]           shadow;
        logic [127:0]           active;
        logic [31:0]            mul_v;
        logic                   mul_valid;
        logic [SEQ_VSR_W-1:0]   vsr;
        logic [SEQ_CNT_W-1:0]   inflight;
    } seq_regs_t;

    localparam seq_regs_t SEQ_RESET = '{
        shadow:    IDENTITY_M,
        active:    IDENTITY_M,
        mul_v:     32'h0,
        mul_valid: 1'b0,
        vsr:       '0,
        inflight:  '0
    };

    function automatic logic [127:0] mtx_write(input logic [127:0] m,
                                               input logic [3:0]   addr,
                                               input logic [7:0]   data);
        logic [127:0] res;
        res = m;
        res[{addr, 3'b000} +: 8] = data;
        return res;
    endfunction

endpackage

// File: rtl/mul_4x4_i8_resq.sv
// In-order result FIFO for the mul_4x4_i8 sequencer. No bypass: a push into an
// empty FIFO becomes visible on o_data/o_valid the following cycle.
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_push, i_data : write one 72-bit result
//   i_pop          : drop the head entry
//   o_data         : head entry
//   o_valid        : FIFO non-empty
//   o_count        : current occupancy
module mul_4x4_i8_resq
    import mul_4x4_i8_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_push,
    input  logic [71:0]          i_data,
    input  logic                 i_pop,
    output logic [71:0]          o_data,
    output logic                 o_valid,
    output logic [SEQ_CNT_W-1:0] o_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [71:0]          r_mem [DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [SEQ_CNT_W-1:0] r_count;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + SEQ_CNT_W'(i_push) - SEQ_CNT_W'(i_pop);
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_valid = (r_count != '0);
    assign o_count = r_count;

    a_no_push_full: assert property (@(posedge i_clk) disable iff (i_rst)
        !(i_push && (r_count == SEQ_CNT_W'(DEPTH))));
    a_no_pop_empty: assert property (@(posedge i_clk) disable iff (i_rst)
        !(i_pop && (r_count == '0)));

endmodule

// File: rtl/mul_4x4_i8_seq.sv
// Issue/collect sequencer for the mul_4x4_i8 matrix-vector multiplier.
// Holds a double-buffered 4x4 int8 matrix, issues accepted vectors to the
// fixed-latency multiplier and collects its results into an in-order FIFO.
//   i_mtx_we/addr/wdata : shadow matrix element write
//   i_mtx_commit        : active <- shadow (same-cycle write forwarded)
//   i_vec_valid/i_vec, o_vec_ready : input vector handshake
//   o_mul_valid/o_mul_m/o_mul_v    : multiplier issue
//   i_mul_res                      : multiplier result, LATENCY cycles later
//   o_res_valid/o_res/i_res_ready  : result handshake
//   o_busy                         : work in flight or results pending
module mul_4x4_i8_seq
    import mul_4x4_i8_seq_pkg::*;
#(
    parameter int LATENCY    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_mtx_we,
    input  logic [3:0]   i_mtx_addr,
    input  logic [7:0]   i_mtx_wdata,
    input  logic         i_mtx_commit,
    input  logic         i_vec_valid,
    input  logic [31:0]  i_vec,
    output logic         o_vec_ready,
    output logic         o_mul_valid,
    output logic [127:0] o_mul_m,
    output logic [31:0]  o_mul_v,
    input  logic [71:0]  i_mul_res,
    output logic         o_res_valid,
    output logic [71:0]  o_res,
    input  logic         i_res_ready,
    output logic         o_busy
);

    seq_regs_t              r_seq;
    seq_regs_t              w_seq_nxt;
    logic [127:0]           w_shadow;
    logic                   w_accept;
    logic                   w_push;
    logic                   w_pop;
    logic [SEQ_CNT_W-1:0]   w_count;
    logic [SEQ_CNT_W:0]     w_credit_used;

    // Credits: every accepted vector reserves a FIFO slot until it is popped,
    // so a result arriving from the multiplier always finds room.
    assign w_credit_used = {1'b0, r_seq.inflight} + {1'b0, w_count};
    assign o_vec_ready   = !i_rst && (w_credit_used < (SEQ_CNT_W + 1)'(FIFO_DEPTH));
    assign w_accept      = i_vec_valid && o_vec_ready;
    // Shift register travels toward bit 0; bit 0 marks the result cycle.
    assign w_push        = r_seq.vsr[0];
    assign w_pop         = o_res_valid && i_res_ready;

    always_comb begin
        w_seq_nxt = r_seq;
        w_shadow  = r_seq.shadow;
        if (i_mtx_we) begin
            w_shadow = mtx_write(r_seq.shadow, i_mtx_addr, i_mtx_wdata);
        end
        w_seq_nxt.shadow = w_shadow;
        if (i_mtx_commit) begin
            w_seq_nxt.active = w_shadow;
        end
        w_seq_nxt.mul_valid = w_accept;
        if (w_accept) begin
            w_seq_nxt.mul_v = i_vec;
        end
        w_seq_nxt.vsr      = (r_seq.vsr >> 1)
                           | (SEQ_VSR_W'(r_seq.mul_valid) << (LATENCY - 1));
        w_seq_nxt.inflight = r_seq.inflight + SEQ_CNT_W'(w_accept) - SEQ_CNT_W'(w_push);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_seq <= SEQ_RESET;
        end else begin
            r_seq <= w_seq_nxt;
        end
    end

    assign o_mul_valid = r_seq.mul_valid;
    assign o_mul_m     = r_seq.active;
    assign o_mul_v     = r_seq.mul_v;
    assign o_busy      = (r_seq.inflight != '0) || o_res_valid;

    mul_4x4_i8_resq #(
        .DEPTH (FIFO_DEPTH)
    ) u_resq (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_data  (i_mul_res),
        .i_pop   (w_pop),
        .o_data  (o_res),
        .o_valid (o_res_valid),
        .o_count (w_count)
    );

endmodule

// File: tb/tb_mul_4x4_i8_seq.sv
// Bench for mul_4x4_i8_seq: directed vectors with hand-computed results,
// a behavioural stand-in for the external multiplier, and a scoreboard
// monitor that checks every popped result in order.
module tb_mul_4x4_i8_seq;

    localparam int LAT   = 2;
    localparam int DEPTH = 4;
    localparam logic [127:0] IDENT = 128'h01000000_00010000_00000100_00000001;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         i_mtx_we;
    logic [3:0]   i_mtx_addr;
    logic [7:0]   i_mtx_wdata;
    logic         i_mtx_commit;
    logic         i_vec_valid;
    logic [31:0]  i_vec;
    logic         o_vec_ready;
    logic         o_mul_valid;
    logic [127:0] o_mul_m;
    logic [31:0]  o_mul_v;
    logic [71:0]  i_mul_res;
    logic         o_res_valid;
    logic [71:0]  o_res;
    logic         i_res_ready;
    logic         o_busy;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        logic [71:0] exp;
        int          acc;
        bit          lat;
    } sb_t;
    sb_t sb[$];

    mul_4x4_i8_seq #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_mtx_we     (i_mtx_we),
        .i_mtx_addr   (i_mtx_addr),
        .i_mtx_wdata  (i_mtx_wdata),
        .i_mtx_commit (i_mtx_commit),
        .i_vec_valid  (i_vec_valid),
        .i_vec        (i_vec),
        .o_vec_ready  (o_vec_ready),
        .o_mul_valid  (o_mul_valid),
        .o_mul_m      (o_mul_m),
        .o_mul_v      (o_mul_v),
        .i_mul_res    (i_mul_res),
        .o_res_valid  (o_res_valid),
        .o_res        (o_res),
        .i_res_ready  (i_res_ready),
        .o_busy       (o_busy)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    // Stand-in for the external multiplier: LAT registered stages.
    function automatic logic [71:0] mul_model(input logic [127:0] m, input logic [31:0] v);
        logic [71:0]        r;
        logic signed [17:0] acc;
        logic signed [17:0] a;
        logic signed [17:0] b;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            acc = '0;
            for (int j = 0; j < 4; j++) begin
                a   = 18'($signed(m[(4*k+j)*8 +: 8]));
                b   = 18'($signed(v[j*8 +: 8]));
                acc = acc + a * b;
            end
            r[18*k +: 18] = acc;
        end
        return r;
    endfunction

    logic [71:0] mpipe [LAT];
    always @(posedge i_clk) begin
        mpipe[0] <= mul_model(o_mul_m, o_mul_v);
        for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end
    assign i_mul_res = mpipe[LAT-1];

    // Identity-matrix result: each lane sign-extended to 18 bits.
    function automatic logic [71:0] ident(input logic [31:0] v);
        logic [71:0] r;
        for (int k = 0; k < 4; k++) r[18*k +: 18] = {{10{v[8*k+7]}}, v[8*k +: 8]};
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare on every pop, in acceptance order.
    always @(negedge i_clk) begin
        #1;
        if (o_res_valid && i_res_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result: got %h expected none", o_res);
            end else begin
                sb_t e;
                e = sb.pop_front();
                chk("result", {56'h0, o_res}, {56'h0, e.exp});
                if (e.lat) chk("latency", 128'(cyc - e.acc), 128'(2 + LAT));
            end
        end
    end

    task automatic send(input logic [31:0] v, input logic [71:0] exp,
                        input bit track, input bit lat);
        int n;
        n = 0;
        i_vec_valid = 1'b1;
        i_vec       = v;
        while (!o_vec_ready && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        if (n >= 200) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got no ready expected ready within 200 cycles");
        end else if (track) begin
            sb.push_back('{exp: exp, acc: cyc, lat: lat});
        end
        @(negedge i_clk);
        i_vec_valid = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d, input bit commit);
        i_mtx_we     = 1'b1;
        i_mtx_addr   = a;
        i_mtx_wdata  = d;
        i_mtx_commit = commit;
        @(negedge i_clk);
        i_mtx_we     = 1'b0;
        i_mtx_commit = 1'b0;
    endtask

    task automatic wait_idle;
        int n;
        n = 0;
        while ((sb.size() != 0 || o_busy) && n < 200) begin
            @(negedge i_clk);
            #2;
            n++;
        end
        tests++;
        if (n >= 200) begin
            fails++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        @(negedge i_clk);
    endtask

    initial begin
        int hi;
        i_rst        = 1'b1;
        i_mtx_we     = 1'b0;
        i_mtx_addr   = '0;
        i_mtx_wdata  = '0;
        i_mtx_commit = 1'b0;
        i_vec_valid  = 1'b0;
        i_vec        = '0;
        i_res_ready  = 1'b1;

        // Reset values
        repeat (2) @(negedge i_clk);
        #1;
        chk("rst_mul_valid", 128'(o_mul_valid), 128'd0);
        chk("rst_mul_v",     128'(o_mul_v),     128'd0);
        chk("rst_mul_m",     o_mul_m,           IDENT);
        chk("rst_res_valid", 128'(o_res_valid), 128'd0);
        chk("rst_busy",      128'(o_busy),      128'd0);
        chk("rst_vec_ready", 128'(o_vec_ready), 128'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        chk("ready_after_rst", 128'(o_vec_ready), 128'd1);
        @(negedge i_clk);

        // Identity after reset, with latency check
        send(32'hFF02FD04, {18'h3FFFF, 18'h00002, 18'h3FFFD, 18'h00004}, 1, 1);
        wait_idle();

        // Shadow isolation: writes without commit leave active at identity
        for (int i = 0; i < 16; i++) wr(4'(i), 8'h03, 1'b0);
        send(32'h08070605, ident(32'h08070605), 1, 1);
        send(32'h807F00FF, ident(32'h807F00FF), 1, 0);
        wait_idle();

        // Extremes; the commit rides on the last write (forwarded)
        for (int i = 0; i < 16; i++) wr(4'(i), 8'h80, i == 15);
        send(32'h80808080, {4{18'h10000}}, 1, 0);
        send(32'h7F7F7F7F, {4{18'h30200}}, 1, 0);
        wait_idle();

        // Restore identity via shadow; back-to-back commits, last wins
        for (int i = 0; i < 16; i++) wr(4'(i), (i % 5 == 0) ? 8'h01 : 8'h00, 1'b0);
        wr(4'd0, 8'h05, 1'b1);
        wr(4'd0, 8'h01, 1'b1);
        send(32'h11F3227E, ident(32'h11F3227E), 1, 0);
        wait_idle();

        // Backpressure: 4 credits, then ready stays low
        i_res_ready = 1'b0;
        send(32'h01020304, ident(32'h01020304), 1, 0);
        send(32'hFEFDFCFB, ident(32'hFEFDFCFB), 1, 0);
        send(32'h10203040, ident(32'h10203040), 1, 0);
        send(32'h7F80017F, ident(32'h7F80017F), 1, 0);
        i_vec_valid = 1'b1;
        i_vec       = 32'h05060708;
        hi = 0;
        repeat (10) begin
            @(negedge i_clk);
            if (o_vec_ready) hi++;
        end
        chk("bp_ready_low", 128'(hi), 128'd0);
        chk("bp_res_valid", 128'(o_res_valid), 128'd1);
        i_res_ready = 1'b1;
        send(32'h05060708, ident(32'h05060708), 1, 0);
        send(32'hF0E0D0C0, ident(32'hF0E0D0C0), 1, 0);
        wait_idle();

        // Same-cycle commit of 2*I
        wr(4'd0, 8'h02, 1'b0);
        wr(4'd5, 8'h02, 1'b0);
        wr(4'd10, 8'h02, 1'b0);
        wr(4'd15, 8'h02, 1'b0);
        send(32'h01010101, {4{18'h00001}}, 1, 0);
        i_mtx_commit = 1'b1;
        send(32'h01010101, {4{18'h00002}}, 1, 0);
        i_mtx_commit = 1'b0;
        wait_idle();

        // Reset with two vectors in flight (active = 2*I)
        send(32'h01020304, '0, 0, 0);
        send(32'h05060708, '0, 0, 0);
        chk("busy_inflight", 128'(o_busy), 128'd1);
        i_rst = 1'b1;
        #1;
        chk("ready_in_rst", 128'(o_vec_ready), 128'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        hi = 0;
        repeat (10) begin
            @(negedge i_clk);
            if (o_res_valid) hi++;
        end
        chk("no_res_after_rst", 128'(hi), 128'd0);
        chk("busy_after_rst", 128'(o_busy), 128'd0);
        send(32'h03FD7F81, ident(32'h03FD7F81), 1, 1);
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
